// File: rtl/decode_in_rec_pkg.sv
// Shared types for the decode-stage input recorder: FSM states, default record layout
// and the drop counter ceiling.
package decode_in_rec_pkg;

   localparam int INSTR_W_DEF = 16;
   localparam int NPC_W_DEF   = 16;
   localparam int SR_W_DEF    = 3;
   localparam int TS_W_DEF    = 16;

   localparam int DROP_CNT_MAX = 255;

   typedef enum logic [1:0] {
      WAIT_RST = 2'd0,
      IDLE     = 2'd1,
      RUN      = 2'd2
   } rec_state_e;

   // Record layout at default widths; the top packs the same field order at any width.
   typedef struct packed {
      logic [INSTR_W_DEF-1:0] instr;
      logic [NPC_W_DEF-1:0]   npc;
      logic [SR_W_DEF-1:0]    sr;
      logic                   en;
      logic [TS_W_DEF-1:0]    ts;
   } decode_in_rec_t;

endpackage

// File: rtl/decode_in_rec_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head data is combinational (visible the cycle after write).
// A write to a full FIFO is accepted only when a read happens in the same cycle.
module decode_in_rec_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   wr_en_i,
   input  logic [WIDTH-1:0]       wr_dat_i,
   input  logic                   rd_en_i,
   output logic [WIDTH-1:0]       rd_dat_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_wr;
   logic             do_rd;

   assign empty_o  = (wr_ptr_q == rd_ptr_q);
   assign full_o   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_rd    = rd_en_i && !empty_o;
   assign do_wr    = wr_en_i && (!full_o || do_rd);
   assign level_o  = wr_ptr_q - rd_ptr_q;
   assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
   end

endmodule

// File: rtl/decode_in_txn_recorder.sv
// Decode-input capture: timestamps qualifying RUN samples into a FIFO (head valid the cycle after);
// full FIFO drops and counts unless popped same cycle. DECODE_IN_REC_DEDUP_EN suppresses repeats.
module decode_in_txn_recorder
   import decode_in_rec_pkg::*;
#(
   parameter int INSTR_W     = 16,
   parameter int NPC_W       = 16,
   parameter int SR_W        = 3,
   parameter int DEPTH       = 8,
   parameter int TS_W        = 16,
   parameter int CAPTURE_ALL = 0
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [INSTR_W-1:0]     instr_dout,
   input  logic [NPC_W-1:0]       npc_in,
   input  logic [SR_W-1:0]        Sr,
   input  logic                   en_decode,
   input  logic                   start,
   input  logic                   stop,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INSTR_W-1:0]     out_instr,
   output logic [NPC_W-1:0]       out_npc,
   output logic [SR_W-1:0]        out_sr,
   output logic                   out_en,
   output logic [TS_W-1:0]        out_ts,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic [7:0]             drop_cnt,
   output logic [1:0]             state_o
);
   localparam int REC_W = INSTR_W + NPC_W + SR_W + 1 + TS_W;

   rec_state_e       state_q, state_d;
   logic [TS_W-1:0]  ts_q, ts_d;
   logic             ovf_q, ovf_d;
   logic [7:0]       drop_q, drop_d;
   logic             start_run;
   logic             qualify;
   logic             dup;
   logic             push_req;
   logic             push_ok;
   logic             drop;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [REC_W-1:0] wr_dat;
   logic [REC_W-1:0] rd_dat;

   always_comb begin
      state_d   = state_q;
      start_run = 1'b0;
      case (state_q)
         WAIT_RST: state_d = IDLE;
         IDLE: begin
            // stop outranks a coincident start
            if (start && !stop) begin
               state_d   = RUN;
               start_run = 1'b1;
            end
         end
         RUN:      if (stop) state_d = IDLE;
         default:  state_d = WAIT_RST;
      endcase
   end

   assign qualify  = (state_q == RUN) && (en_decode || (CAPTURE_ALL != 0));
   assign push_req = qualify && !dup;
   assign pop      = out_ready && !fifo_empty;
   assign push_ok  = push_req && (!fifo_full || pop);
   assign drop     = push_req && !push_ok;
   assign wr_dat   = {instr_dout, npc_in, Sr, en_decode, ts_q};

`ifdef DECODE_IN_REC_DEDUP_EN
   logic [INSTR_W+NPC_W+SR_W-1:0] last_key_q;
   logic                          last_vld_q;

   assign dup = last_vld_q && (last_key_q == {instr_dout, npc_in, Sr});

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_key_q <= '0;
         last_vld_q <= 1'b0;
      end else if (start_run) begin
         last_vld_q <= 1'b0;
      end else if (push_ok) begin
         last_key_q <= {instr_dout, npc_in, Sr};
         last_vld_q <= 1'b1;
      end
   end
`else
   assign dup = 1'b0;
`endif

   always_comb begin
      ts_d = ts_q;
      if (start_run)             ts_d = '0;
      else if (state_q == RUN)   ts_d = ts_q + 1'b1;
   end

   assign ovf_d  = ovf_q | drop;
   assign drop_d = (drop && (drop_q != 8'(DROP_CNT_MAX))) ? drop_q + 8'd1 : drop_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= WAIT_RST;
         ts_q    <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         ts_q    <= ts_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   decode_in_rec_fifo #(
      .WIDTH (REC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i    (clock),
      .rst_i    (reset),
      .wr_en_i  (push_req),
      .wr_dat_i (wr_dat),
      .rd_en_i  (out_ready),
      .rd_dat_o (rd_dat),
      .full_o   (fifo_full),
      .empty_o  (fifo_empty),
      .level_o  (level)
   );

   // Record fields are forced to zero while empty so reset leaves every output at 0.
   assign out_valid = !fifo_empty;
   assign {out_instr, out_npc, out_sr, out_en, out_ts} = out_valid ? rd_dat : '0;
   assign overflow  = ovf_q;
   assign drop_cnt  = drop_q;
   assign state_o   = state_q;

endmodule

// File: tb/tb_decode_in_txn_recorder.sv
// Bench for decode_in_txn_recorder: a default instance and a CAPTURE_ALL=1/TS_W=4 instance share
// stimulus; a queue-level reference model checks both every cycle alongside directed vectors.
module tb_decode_in_txn_recorder;
   localparam int DEPTH = 8;
`ifdef DECODE_IN_REC_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] instr_dout = '0;
   logic [15:0] npc_in = '0;
   logic [2:0]  sr = '0;
   logic        en_decode = 1'b0, start = 1'b0, stop = 1'b0, out_ready = 1'b0;

   logic        a_vld, a_en, a_ovf;
   logic [15:0] a_instr, a_npc, a_ts;
   logic [2:0]  a_sr;
   logic [3:0]  a_level;
   logic [7:0]  a_drop;
   logic [1:0]  a_state;

   logic        b_vld, b_en, b_ovf;
   logic [15:0] b_instr, b_npc;
   logic [3:0]  b_ts;
   logic [2:0]  b_sr;
   logic [3:0]  b_level;
   logic [7:0]  b_drop;
   logic [1:0]  b_state;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   decode_in_txn_recorder #(.DEPTH(DEPTH), .CAPTURE_ALL(0)) dut (
      .clock(clock), .reset(reset), .instr_dout(instr_dout), .npc_in(npc_in), .Sr(sr),
      .en_decode(en_decode), .start(start), .stop(stop), .out_valid(a_vld), .out_ready(out_ready),
      .out_instr(a_instr), .out_npc(a_npc), .out_sr(a_sr), .out_en(a_en), .out_ts(a_ts),
      .level(a_level), .overflow(a_ovf), .drop_cnt(a_drop), .state_o(a_state));

   decode_in_txn_recorder #(.DEPTH(DEPTH), .TS_W(4), .CAPTURE_ALL(1)) dut_b (
      .clock(clock), .reset(reset), .instr_dout(instr_dout), .npc_in(npc_in), .Sr(sr),
      .en_decode(en_decode), .start(start), .stop(stop), .out_valid(b_vld), .out_ready(out_ready),
      .out_instr(b_instr), .out_npc(b_npc), .out_sr(b_sr), .out_en(b_en), .out_ts(b_ts),
      .level(b_level), .overflow(b_ovf), .drop_cnt(b_drop), .state_o(b_state));

   // Reference model: per instance a circular record store plus mode/timestamp integers.
   typedef struct { int instr; int npc; int sr; int en; int ts; } rec_t;
   rec_t   mbuf [2][DEPTH];
   int     mhead[2], mcnt[2], mstate[2], mts[2], movf[2], mdrop[2], mlast_vld[2];
   longint mlast[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic m_step(input int i, input bit capall, input int tsmod);
      longint key;
      if (reset) begin
         mhead[i] = 0; mcnt[i] = 0; mstate[i] = 0; mts[i] = 0;
         movf[i] = 0; mdrop[i] = 0; mlast_vld[i] = 0;
         return;
      end
      if (mcnt[i] > 0 && out_ready) begin
         mhead[i] = (mhead[i] + 1) % DEPTH;
         mcnt[i]--;
      end
      case (mstate[i])
         0: mstate[i] = 1;
         1: if (start && !stop) begin
               mstate[i] = 2; mts[i] = 0; mlast_vld[i] = 0;
            end
         default: begin
            key = 64'({instr_dout, npc_in, sr});
            if ((en_decode || capall) && !(DEDUP && mlast_vld[i] != 0 && mlast[i] == key)) begin
               if (mcnt[i] == DEPTH) begin
                  movf[i] = 1;
                  if (mdrop[i] < 255) mdrop[i]++;
               end else begin
                  mbuf[i][(mhead[i] + mcnt[i]) % DEPTH] =
                     '{int'(instr_dout), int'(npc_in), int'(sr), int'(en_decode), mts[i]};
                  mcnt[i]++;
                  mlast[i] = key;
                  mlast_vld[i] = 1;
               end
            end
            mts[i] = (mts[i] + 1) % tsmod;
            if (stop) mstate[i] = 1;
         end
      endcase
   endtask

   task automatic m_check();
      rec_t r;
      chk("a_state", 32'(a_state), mstate[0]);
      chk("a_vld", 32'(a_vld), 32'(mcnt[0] > 0));
      chk("a_level", 32'(a_level), mcnt[0]);
      chk("a_ovf", 32'(a_ovf), movf[0]);
      chk("a_drop", 32'(a_drop), mdrop[0]);
      if (mcnt[0] > 0) begin
         r = mbuf[0][mhead[0]];
         chk("a_instr", 32'(a_instr), r.instr);
         chk("a_npc", 32'(a_npc), r.npc);
         chk("a_sr", 32'(a_sr), r.sr);
         chk("a_en", 32'(a_en), r.en);
         chk("a_ts", 32'(a_ts), r.ts);
      end
      chk("b_state", 32'(b_state), mstate[1]);
      chk("b_vld", 32'(b_vld), 32'(mcnt[1] > 0));
      chk("b_level", 32'(b_level), mcnt[1]);
      chk("b_ovf", 32'(b_ovf), movf[1]);
      chk("b_drop", 32'(b_drop), mdrop[1]);
      if (mcnt[1] > 0) begin
         r = mbuf[1][mhead[1]];
         chk("b_instr", 32'(b_instr), r.instr);
         chk("b_npc", 32'(b_npc), r.npc);
         chk("b_sr", 32'(b_sr), r.sr);
         chk("b_en", 32'(b_en), r.en);
         chk("b_ts", 32'(b_ts), r.ts);
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      m_step(0, 1'b0, 65536);
      m_step(1, 1'b1, 16);
      #1;
      m_check();
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; stop = 1'b0; en_decode = 1'b0; out_ready = 1'b0;
      cycle();
      reset = 1'b0;
      cycle();
   endtask

   typedef struct {
      logic start, stop, en, rdy;
      logic [15:0] instr, npc;
      logic [2:0]  sr;
      logic [1:0]  st;
      logic        vld;
      logic [3:0]  lvl;
      logic [15:0] oinstr, onpc, ots;
   } vec_t;
   vec_t vt [8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   initial begin
      vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 2'd1, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'd0};
      vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 3'd0, 2'd2, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'd0};
      vt[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0100, 3'd1, 2'd2, 1'b1, 4'd1, 16'h1234, 16'h0100, 16'd0};
      vt[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h5678, 16'h0102, 3'd2, 2'd2, 1'b1, 4'd2, 16'h1234, 16'h0100, 16'd0};
      vt[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'h9ABC, 16'h0104, 3'd3, 2'd1, 1'b1, 4'd3, 16'h1234, 16'h0100, 16'd0};
      vt[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 3'd7, 2'd1, 1'b1, 4'd2, 16'h5678, 16'h0102, 16'd1};
      vt[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0, 2'd1, 1'b1, 4'd1, 16'h9ABC, 16'h0104, 16'd2};
      vt[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 3'd0, 2'd1, 1'b0, 4'd0, 16'h0000, 16'h0000, 16'd0};

      // Reset state
      cycle();
      cycle();
      chk("rst_state", 32'(a_state), 32'd0);
      chk("rst_vld", 32'(a_vld), 32'd0);
      chk("rst_level", 32'(a_level), 32'd0);
      chk("rst_ovf", 32'(a_ovf), 32'd0);
      chk("rst_drop", 32'(a_drop), 32'd0);
      chk("rst_instr", 32'(a_instr), 32'd0);
      chk("rst_ts", 32'(a_ts), 32'd0);
      reset = 1'b0;

      // Three-record capture and drain
      for (int i = 0; i < 8; i++) begin
         start = vt[i].start; stop = vt[i].stop; en_decode = vt[i].en; out_ready = vt[i].rdy;
         instr_dout = vt[i].instr; npc_in = vt[i].npc; sr = vt[i].sr;
         cycle();
         chk("vec_state", 32'(a_state), 32'(vt[i].st));
         chk("vec_vld", 32'(a_vld), 32'(vt[i].vld));
         chk("vec_level", 32'(a_level), 32'(vt[i].lvl));
         if (vt[i].vld) begin
            chk("vec_instr", 32'(a_instr), 32'(vt[i].oinstr));
            chk("vec_npc", 32'(a_npc), 32'(vt[i].onpc));
            chk("vec_ts", 32'(a_ts), 32'(vt[i].ots));
         end
      end

      // Overflow: 10 samples into 8 entries, then full push with simultaneous pop
      do_reset();
      start = 1'b1; cycle(); start = 1'b0;
      en_decode = 1'b1;
      for (int k = 0; k < 10; k++) begin
         instr_dout = 16'(k); cycle();
      end
      chk("ovf_level", 32'(a_level), 32'd8);
      chk("ovf_flag", 32'(a_ovf), 32'd1);
      chk("ovf_drop", 32'(a_drop), 32'd2);
      out_ready = 1'b1; stop = 1'b1; instr_dout = 16'hAAAA;
      cycle();
      stop = 1'b0; en_decode = 1'b0;
      chk("fullpop_level", 32'(a_level), 32'd8);
      chk("fullpop_drop", 32'(a_drop), 32'd2);
      for (int k = 0; k < 8; k++) begin
         chk("drain_vld", 32'(a_vld), 32'd1);
         chk("drain_ts", 32'(a_ts), (k < 7) ? 32'(k + 1) : 32'd10);
         cycle();
      end
      chk("drain_empty", 32'(a_vld), 32'd0);
      chk("ovf_sticky", 32'(a_ovf), 32'd1);

      // en_decode toggling 1,0,1,0
      do_reset();
      start = 1'b1; cycle(); start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         en_decode = (k % 2 == 0); instr_dout = 16'(16'h100 + k); stop = (k == 3);
         cycle();
      end
      stop = 1'b0; en_decode = 1'b0;
      chk("tog_a_level", 32'(a_level), 32'd2);
      chk("tog_b_level", 32'(b_level), 32'd4);
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         chk("tog_b_en", 32'(b_en), 32'(k % 2 == 0));
         chk("tog_b_ts", 32'(b_ts), 32'(k));
         if (k < 2) chk("tog_a_ts", 32'(a_ts), 32'(2 * k));
         cycle();
      end

      // Timestamp wrap with continuous drain, start ignored in RUN, async reset mid-RUN
      do_reset();
      start = 1'b1; cycle(); start = 1'b0;
      out_ready = 1'b1; en_decode = 1'b1;
      for (int k = 0; k < 20; k++) begin
         instr_dout = 16'(k); start = (k == 10);
         cycle();
         chk("wrap_state", 32'(b_state), 32'd2);
         chk("wrap_ts", 32'(b_ts), 32'(k % 16));
      end
      start = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk("arst_b_vld", 32'(b_vld), 32'd0);
      chk("arst_b_level", 32'(b_level), 32'd0);
      chk("arst_b_state", 32'(b_state), 32'd0);
      chk("arst_a_state", 32'(a_state), 32'd0);
      cycle();
      reset = 1'b0;

`ifdef DECODE_IN_REC_DEDUP_EN
      // Repeated samples suppressed; first sample of a run always pushes
      do_reset();
      start = 1'b1; cycle(); start = 1'b0;
      en_decode = 1'b1; instr_dout = 16'h1111; npc_in = 16'h2222; sr = 3'd5;
      for (int k = 0; k < 4; k++) cycle();
      instr_dout = 16'h3333; stop = 1'b1;
      cycle();
      stop = 1'b0; en_decode = 1'b0;
      chk("dedup_level", 32'(a_level), 32'd2);
      chk("dedup_drop", 32'(a_drop), 32'd0);
      chk("dedup_ts0", 32'(a_ts), 32'd0);
      out_ready = 1'b1;
      cycle();
      chk("dedup_ts1", 32'(a_ts), 32'd4);
      chk("dedup_instr1", 32'(a_instr), 32'h3333);
`endif

      // Randomised traffic against the model
      do_reset();
      for (int k = 0; k < 600; k++) begin
         int rp;
         rp = ((k / 50) % 2 == 1) ? 3 : 1;
         reset      = ($urandom_range(99) == 0);
         start      = ($urandom_range(15) == 0);
         stop       = ($urandom_range(15) == 0);
         en_decode  = 1'($urandom_range(1));
         out_ready  = ($urandom_range(3) < rp);
         instr_dout = 16'($urandom_range(3));
         npc_in     = 16'($urandom_range(1));
         sr         = 3'($urandom_range(1));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
